fpmul_share_arbiter: RTL

- Shares one pipelined FP32 multiplier datapath among NUM_REQ neuron-side requesters.
- Round-robin arbitration issues at most one operand pair per cycle to the multiplier.
- Tracks the requester ID of every in-flight operation in a tag pipeline matched to the multiplier latency.
- Routes each returning product to the requester that issued it. Sits between the neuron MAC sequencers and the shared multiplier instance.

---
 rtl/fpmul_share_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fpmul_share_arbiter.sv
// Round-robin share arbiter for one pipelined FP32 multiplier with per-requester tag return.
// Optional per-requester handshake counters are enabled by defining FPMUL_ARB_STATS_EN.
module fpmul_share_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int MUL_LATENCY = 3,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*32-1:0]   req_a_i,
    input  logic [NUM_REQ*32-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    mul_valid_o,
    output logic [31:0]             mul_a_o,
    output logic [31:0]             mul_b_o,
    input  logic [31:0]             mul_result_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic                    busy_o
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   grant_count_o
`endif
);

    logic [NUM_REQ-1:0] outstanding_r;
    logic [NUM_REQ-1:0] outst_eff_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] rsp_vld_s;
    logic [31:0]        rsp_data_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    gnt_id_s;
    logic [ID_W-1:0]    nxt_ptr_s;
    logic [ID_W:0]      idx_s;
    logic               gnt_any_s;

    logic               mul_valid_r;
    logic [31:0]        mul_a_r;
    logic [31:0]        mul_b_r;
    logic [ID_W-1:0]    issue_id_r;

    logic [MUL_LATENCY-1:0] tag_vld_r;
    logic [ID_W-1:0]        tag_id_r [MUL_LATENCY];

    // A responding requester is already free this cycle so it can be regranted immediately.
    assign outst_eff_s = outstanding_r & ~rsp_vld_s;
    assign eligible_s  = req_valid_i & ~outst_eff_s & {NUM_REQ{~reset_i}};

    // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_id_s  = '0;
        idx_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!gnt_any_s && eligible_s[idx_s[ID_W-1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_id_s  = idx_s[ID_W-1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // One-hot grant and the pointer value that follows it.
    always_comb begin
        grant_s   = '0;
        nxt_ptr_s = rr_ptr_r;
        if (gnt_any_s) begin
            grant_s[gnt_id_s] = 1'b1;
            if (gnt_id_s == ID_W'(NUM_REQ-1)) begin
                nxt_ptr_s = '0;
            end else begin
                nxt_ptr_s = gnt_id_s + ID_W'(1);
            end
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready_o = grant_s;

    // Issue register, round-robin pointer and outstanding bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mul_valid_r   <= 1'b0;
            mul_a_r       <= 32'h0;
            mul_b_r       <= 32'h0;
            issue_id_r    <= '0;
            rr_ptr_r      <= '0;
            outstanding_r <= '0;
        end else begin
            outstanding_r <= outst_eff_s | grant_s;
            if (gnt_any_s) begin
                mul_valid_r <= 1'b1;
                mul_a_r     <= req_a_i[gnt_id_s*32 +: 32];
                mul_b_r     <= req_b_i[gnt_id_s*32 +: 32];
                issue_id_r  <= gnt_id_s;
                rr_ptr_r    <= nxt_ptr_s;
            end else begin
                mul_valid_r <= 1'b0;
            end
        end
    end

    // Tag pipeline mirroring the multiplier latency.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_vld_r <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_vld_r[0] <= mul_valid_r;
            tag_id_r[0]  <= issue_id_r;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    // Route the returning product to the requester recorded in the last tag stage.
    always_comb begin
        rsp_vld_s  = '0;
        rsp_data_s = 32'h0;
        if (tag_vld_r[MUL_LATENCY-1]) begin
            rsp_vld_s[tag_id_r[MUL_LATENCY-1]] = 1'b1;
            rsp_data_s = mul_result_i;
        end else begin
            rsp_data_s = 32'h0;
        end
    end

    assign rsp_valid_o = rsp_vld_s;
    assign rsp_data_o  = rsp_data_s;
    assign mul_valid_o = mul_valid_r;
    assign mul_a_o     = mul_a_r;
    assign mul_b_o     = mul_b_r;
    assign busy_o      = |outstanding_r;

`ifdef FPMUL_ARB_STATS_EN
    logic [15:0] cnt_r [NUM_REQ];

    // Saturating handshake counters, one per requester.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= 16'h0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten counters onto the packed output.
    always_comb begin
        grant_count_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count_o[i*16 +: 16] = cnt_r[i];
        end
    end
`endif

endmodule
